// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide execution unit. Takes one operation at a
//   time from the register-file read ports, runs a 32-step radix-2 datapath
//   (shift-add multiply, restoring divide) on operand magnitudes, applies the
//   sign correction on the last step and emits a one-cycle writeback pulse.
//   Divide-by-zero and signed overflow bypass the iteration entirely.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous, active-high reset
//   valid_i   in   operation request (accepted when ready_o=1 and kill_i=0)
//   ready_o   out  unit idle, can accept
//   op_i      in   funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1_i     in   operand a
//   rs2_i     in   operand b
//   rd_i      in   destination register index
//   kill_i    in   abort in-flight op; also suppresses a pending result pulse
//   valid_o   out  result valid, one-cycle pulse
//   result_o  out  result (register-file wdata)
//   rd_o      out  destination (register-file waddr)
//   we_o      out  register-file write enable (valid_o and rd_o != 0)
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [2:0]            op_i,
   input  logic [DATA_WIDTH-1:0] rs1_i,
   input  logic [DATA_WIDTH-1:0] rs2_i,
   input  logic [ADDR_WIDTH-1:0] rd_i,
   input  logic                  kill_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [ADDR_WIDTH-1:0] rd_o,
   output logic                  we_o
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } op_e;

   // Control state (reset) and datapath state (no reset).
   state_e              state_q, state_d;
   logic [W-1:0]        result_q, result_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;

   op_e                 op_q, op_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                neg_q, neg_d;   // final result must be negated
   logic [W-1:0]        hi_q, hi_d;     // product high half / partial remainder
   logic [W-1:0]        lo_q, lo_d;     // multiplier -> product low / dividend -> quotient
   logic [W-1:0]        b_q, b_d;       // multiplicand or divisor magnitude

   // ------------------------------------------------------------------------
   // Acceptance decode: operand signs, magnitudes and fast-path detection.
   // ------------------------------------------------------------------------
   logic          a_signed, b_signed, a_neg, b_neg;
   logic          div_zero, div_ovf, fast;
   logic [W-1:0]  a_mag, b_mag, fast_res;

   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // that no path leaves it unassigned and a latch is never inferred.
      a_signed = 1'b0;
      b_signed = 1'b0;
      a_neg    = 1'b0;
      b_neg    = 1'b0;
      a_mag    = rs1_i;
      b_mag    = rs2_i;
      div_zero = 1'b0;
      div_ovf  = 1'b0;
      fast     = 1'b0;
      fast_res = '0;

      // MUL is treated as signed x signed; its low half is identical either way.
      a_signed = op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      b_signed = op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
      a_neg    = a_signed && rs1_i[W-1];
      b_neg    = b_signed && rs2_i[W-1];
      if (a_neg) a_mag = -rs1_i;
      if (b_neg) b_mag = -rs2_i;

      div_zero = op_i[2] && (rs2_i == '0);
      div_ovf  = (op_i == OP_DIV || op_i == OP_REM) &&
                 (rs1_i == {1'b1, {(W-1){1'b0}}}) && (rs2_i == '1);
      fast     = div_zero || div_ovf;

      // op_i[1] separates REM/REMU from DIV/DIVU.
      if (div_zero) fast_res = op_i[1] ? rs1_i : '1;
      else          fast_res = op_i[1] ? '0    : rs1_i;
   end

   // ------------------------------------------------------------------------
   // One radix-2 step plus the sign-corrected final result.
   // ------------------------------------------------------------------------
   logic [W:0]     mul_sum, div_shift;
   logic           div_ge;
   logic [W-1:0]   div_diff, step_hi, step_lo;
   logic [2*W-1:0] product;
   logic [W-1:0]   quot, remd, final_res;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {W{1'b0}})};
      div_shift = {hi_q, lo_q[W-1]};
      div_ge    = div_shift >= {1'b0, b_q};
      // When div_ge holds the true difference is below the divisor, so the
      // low W bits of the subtraction are exact.
      div_diff  = div_shift[W-1:0] - b_q;

      if (op_q[2]) begin
         step_hi = div_ge ? div_diff : div_shift[W-1:0];
         step_lo = {lo_q[W-2:0], div_ge};
      end else begin
         step_hi = mul_sum[W:1];
         step_lo = {mul_sum[0], lo_q[W-1:1]};
      end

      product = {step_hi, step_lo};
      quot    = step_lo;
      remd    = step_hi;
      if (neg_q) begin
         product = -product;
         quot    = -quot;
         remd    = -remd;
      end

      final_res = '0;
      unique case (op_q)
         OP_MUL:                         final_res = product[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:   final_res = product[2*W-1:W];
         OP_DIV, OP_DIVU:                final_res = quot;
         OP_REM, OP_REMU:                final_res = remd;
         default:                        final_res = '0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-state logic.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      rd_d     = rd_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;

      unique case (state_q)
         IDLE: begin
            if (valid_i && !kill_i) begin
               op_d  = op_e'(op_i);
               rd_d  = rd_i;
               neg_d = (op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
               hi_d  = '0;
               lo_d  = op_i[2] ? a_mag : b_mag;
               b_d   = op_i[2] ? b_mag : a_mag;
               cnt_d = CW'(W - 1);
               if (fast) begin
                  result_d = fast_res;
                  state_d  = DONE;
               end else begin
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            if (kill_i) begin
               state_d = IDLE;
            end else begin
               hi_d  = step_hi;
               lo_d  = step_lo;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  result_d = final_res;
                  state_d  = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is always written with non-blocking assignments so
   // every register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         rd_q     <= rd_d;
      end
   end

   // NOTE: the iteration datapath carries no reset; it is fully reloaded on
   // every acceptance and never observed outside CALC.
   always_ff @(posedge clk) begin
      op_q  <= op_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
   end

   // kill_i suppresses the pulse combinationally in the DONE cycle.
   assign ready_o  = (state_q == IDLE);
   assign valid_o  = (state_q == DONE) && !kill_i;
   assign we_o     = valid_o && (rd_q != '0);
   assign result_o = result_q;
   assign rd_o     = rd_q;

endmodule
